// File: rtl/keypad_emulator_if.sv
// Command and column-scan signals between the keypad emulator and its harness.
// The harness (scanner side) uses the master modport; the emulator uses slave.
interface keypad_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid,
        output cmd_key,
        output col,
        input  cmd_ready,
        input  row,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  col,
        output cmd_ready,
        output row,
        output busy,
        output done
    );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 membrane keypad model: answers an active-low column scan with active-low
// rows for one commanded press, sequenced through bounce, hold and release.
module keypad_emulator #(
    parameter int BOUNCE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int RELEASE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    keypad_emulator_if.slave   kp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BOUNCE  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    // Terminal counter values; each phase counts 0..N-1.
    localparam logic [15:0] B_LAST = (BOUNCE_CYCLES > 0) ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
    localparam logic [15:0] H_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] R_LAST = 16'(RELEASE_CYCLES - 1);
    localparam state_e      FIRST_PRESS_STATE = (BOUNCE_CYCLES == 0) ? HOLD : BOUNCE;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        contact_q, contact_d;
    logic        done_q, done_d;
    logic [3:0]  key_q, key_d;

    logic        accept;
    logic [15:0] cnt_inc;

    // Active-low one-hot select: index 0 drives bit 3 low.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

    assign kp.cmd_ready = (state_q == IDLE) && !rst;
    assign accept       = kp.cmd_valid && kp.cmd_ready;
    assign cnt_inc      = cnt_q + 16'd1;

    // contact_d is computed from the next counter value so the registered
    // contact already reflects the phase in the first cycle of that phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        contact_d = contact_q;
        done_d    = 1'b0;
        key_d     = key_q;
        case (state_q)
            IDLE: begin
                contact_d = 1'b0;
                if (accept) begin
                    key_d     = kp.cmd_key;
                    cnt_d     = 16'd0;
                    contact_d = 1'b1;
                    state_d   = FIRST_PRESS_STATE;
                end
            end
            BOUNCE: begin
                if (cnt_q == B_LAST) begin
                    state_d   = HOLD;
                    cnt_d     = 16'd0;
                    contact_d = 1'b1;
                end else begin
                    cnt_d     = cnt_inc;
                    contact_d = ~cnt_inc[0];
                end
            end
            HOLD: begin
                if (cnt_q == H_LAST) begin
                    state_d   = RELEASE;
                    cnt_d     = 16'd0;
                    contact_d = 1'b0;
                end else begin
                    cnt_d     = cnt_inc;
                    contact_d = 1'b1;
                end
            end
            RELEASE: begin
                contact_d = 1'b0;
                if (cnt_q == R_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = 16'd0;
                contact_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            contact_q <= contact_d;
            done_q    <= done_d;
        end
    end

    // The latched key only matters while contact is set, so it needs no reset.
    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    // Zero-latency row response: only an exact single-column match answers.
    assign kp.row  = (contact_q && (kp.col == one_cold(key_q[1:0])))
                     ? one_cold(key_q[3:2]) : 4'b1111;
    assign kp.busy = (state_q != IDLE);
    assign kp.done = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (default timing and no-bounce) share
// one stimulus stream and are compared every cycle against a press-timeline model.
module tb_keypad_emulator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keypad_emulator_if kif0 ();
    keypad_emulator_if kif1 ();

    assign kif1.cmd_valid = kif0.cmd_valid;
    assign kif1.cmd_key   = kif0.cmd_key;
    assign kif1.col       = kif0.col;

    keypad_emulator dut0 (
        .clk (clk),
        .rst (rst),
        .kp  (kif0)
    );

    keypad_emulator #(
        .BOUNCE_CYCLES  (0),
        .HOLD_CYCLES    (6),
        .RELEASE_CYCLES (3)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .kp  (kif1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a press is a timeline indexed by k = cycles since accept
    // (1-based). Idle when m_act = 0.
    int         pb [2] = '{4, 0};
    int         ph [2] = '{16, 6};
    int         pr [2] = '{8, 3};
    bit         m_act  [2];
    int         m_k    [2];
    bit         m_done [2];
    logic [3:0] m_key  [2];

    function automatic bit m_contact(input int d);
        int k;
        if (!m_act[d]) return 1'b0;
        k = m_k[d];
        if (k <= pb[d]) return ((k - 1) % 2) == 0;
        if (k <= pb[d] + ph[d]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_row(input bit contact, input logic [3:0] col,
                                           input logic [3:0] key);
        int zeros;
        int r;
        int c;
        logic [3:0] v;
        zeros = 0;
        r = int'(key[3:2]);
        c = int'(key[1:0]);
        for (int i = 0; i < 4; i++) if (col[i] == 1'b0) zeros++;
        if (!contact || zeros != 1 || col[3 - c] != 1'b0) return 4'b1111;
        v = 4'b1111;
        v[3 - r] = 1'b0;
        return v;
    endfunction

    task automatic check_outputs();
        logic [3:0] row;
        logic rdy, bsy, dn;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                row = kif0.row; rdy = kif0.cmd_ready; bsy = kif0.busy; dn = kif0.done;
            end else begin
                row = kif1.row; rdy = kif1.cmd_ready; bsy = kif1.busy; dn = kif1.done;
            end
            check($sformatf("d%0d_row", d), 32'(row),
                  32'(exp_row(m_contact(d), kif0.col, m_key[d])));
            check($sformatf("d%0d_ready", d), 32'(rdy), 32'(!m_act[d] && !rst));
            check($sformatf("d%0d_busy", d), 32'(bsy), 32'(m_act[d]));
            check($sformatf("d%0d_done", d), 32'(dn), 32'(m_done[d]));
        end
    endtask

    task automatic model_step();
        int  t;
        bit  nd;
        for (int d = 0; d < 2; d++) begin
            t  = pb[d] + ph[d] + pr[d];
            nd = m_act[d] && (m_k[d] == t);
            if (rst) begin
                m_act[d]  = 1'b0;
                m_done[d] = 1'b0;
            end else begin
                if (m_act[d]) begin
                    if (m_k[d] == t) m_act[d] = 1'b0;
                    else m_k[d] = m_k[d] + 1;
                end else if (kif0.cmd_valid) begin
                    m_act[d] = 1'b1;
                    m_k[d]   = 1;
                    m_key[d] = kif0.cmd_key;
                end
                m_done[d] = nd;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle();
        kif0.cmd_valid = 1'b0;
        for (int i = 0; i < 100 && (m_act[0] || m_act[1]); i++) tick();
        tick();
    endtask

    logic [3:0] cols [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    bit got_key9;
    logic [3:0] rnd4;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_k[d] = 0; m_done[d] = 1'b0; m_key[d] = 4'd0;
        end
        rst            = 1'b1;
        kif0.cmd_valid = 1'b1;
        kif0.cmd_key   = 4'd0;
        kif0.col       = 4'b0111;
        @(posedge clk);
        #1;

        // Reset held with a pending command, then accepted on first free cycle.
        tick();
        tick();
        rst = 1'b0;
        tick();
        kif0.cmd_valid = 1'b0;
        for (int i = 0; i < 32; i++) tick();

        // Key 6 with the scanner cycling all four columns.
        wait_idle();
        kif0.cmd_key   = 4'd6;
        kif0.cmd_valid = 1'b1;
        tick();
        kif0.cmd_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            kif0.col = cols[i % 4];
            tick();
        end

        // No-column and multi-column drive during hold.
        wait_idle();
        kif0.cmd_key   = 4'd0;
        kif0.col       = 4'b0111;
        kif0.cmd_valid = 1'b1;
        tick();
        kif0.cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        kif0.col = 4'b1111; tick();
        kif0.col = 4'b0011; tick();
        kif0.col = 4'b0111; tick();
        for (int i = 0; i < 20; i++) tick();

        // New key offered while busy; held until taken on the done cycle.
        wait_idle();
        kif0.cmd_key   = 4'd5;
        kif0.col       = 4'b1011;
        kif0.cmd_valid = 1'b1;
        tick();
        tick();
        kif0.cmd_key = 4'd9;
        got_key9 = 1'b0;
        for (int i = 0; i < 80 && !got_key9; i++) begin
            if (i % 3 == 0) kif0.col = 4'b1011;
            else kif0.col = 4'b1101;
            tick();
            got_key9 = m_act[0] && (m_key[0] == 4'd9);
        end
        check("b2b_accept_seen", 32'(got_key9), 32'd1);
        kif0.cmd_valid = 1'b0;
        for (int i = 0; i < 35; i++) begin
            kif0.col = (i % 2 == 0) ? 4'b1011 : 4'b1101;
            tick();
        end

        // Reset during the fifth hold cycle of the default instance.
        wait_idle();
        kif0.cmd_key   = 4'd0;
        kif0.col       = 4'b0111;
        kif0.cmd_valid = 1'b1;
        tick();
        kif0.cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            kif0.cmd_valid = ($urandom_range(0, 3) == 0);
            kif0.cmd_key   = 4'($urandom_range(0, 15));
            rnd4           = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) kif0.col = rnd4;
            else kif0.col = cols[rnd4[1:0]];
            tick();
        end
        rst = 1'b0;
        kif0.cmd_valid = 1'b0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Behavioural model of the 4x4 membrane keypad, acting as the responder side of the column-scan interface: it observes the active-low column drive produced by the keypad scanner and returns active-low row signals for one commanded key press. Each press runs through contact bounce, a stable hold period and a release gap. It sits in the test harness and self-test path in place of the physical keypad and is driven by a simple valid/ready command port.

## Interface

Parameters:
- BOUNCE_CYCLES, 4: clock cycles of alternating contact at press onset (0 = no bounce)
- HOLD_CYCLES, 16: clock cycles of stable closed contact (>= 1)
- RELEASE_CYCLES, 8: clock cycles of open contact before the command completes (>= 1)
- All three are < 65536 (16-bit phase counter).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  press request
- cmd_ready  out  1  emulator can accept a request
- cmd_key  in  4  key index: row r = cmd_key[3:2], column c = cmd_key[1:0]
- col  in  4  column drive from scanner, active low; column c active when col = ~(4'b1000 >> c)
- row  out  4  row response, active low; 4'b1111 = no contact
- busy  out  1  press sequence in progress
- done  out  1  one-cycle pulse at sequence completion

## Operation

- States: IDLE, BOUNCE, HOLD, RELEASE. A registered `contact` bit, latched key and 16-bit phase counter.
- IDLE: cmd_ready = 1 (0 while rst is high). On cmd_valid && cmd_ready: latch cmd_key, clear counter, go to BOUNCE (or HOLD if BOUNCE_CYCLES = 0).
- BOUNCE: contact = 1 on even counter values, 0 on odd (pattern 1,0,1,0...). After BOUNCE_CYCLES cycles -> HOLD.
- HOLD: contact = 1 for HOLD_CYCLES cycles -> RELEASE.
- RELEASE: contact = 0 for RELEASE_CYCLES cycles -> IDLE, with done = 1 in the first IDLE cycle.
- busy = (state != IDLE). cmd_ready = (state == IDLE) && !rst. Commands presented while busy are not accepted; cmd_key is not sampled.
- Row response is combinational from col and registered state: row = ~(4'b1000 >> r) when contact = 1 and col equals exactly ~(4'b1000 >> c); otherwise 4'b1111. col values of all-ones, multiple low bits, or a non-matching column give 4'b1111.
- Only one key is modelled at a time; there are no ghosting or multi-key effects.

## Timing

- Reset: in the cycle after rst is sampled high, state = IDLE, contact = 0, row = 4'b1111, busy = 0, done = 0. cmd_ready is 0 while rst is high, so no command is accepted in a reset cycle.
- Reset mid-sequence aborts immediately. No done pulse is produced, and the latched key is discarded.
- If a command is accepted at edge N, the first BOUNCE cycle is N+1. BOUNCE occupies N+1..N+B, HOLD N+B+1..N+B+H, and RELEASE N+B+H+1..N+B+H+R. done and cmd_ready are both 1 at N+B+H+R+1.
- busy is high for exactly B+H+R cycles per command.
- Back-to-back operation: a command held valid is accepted on the done cycle, so the next BOUNCE starts one cycle later. There is one idle cycle between sequences.
- row reacts to col changes in the same cycle (zero latency), so a scanner that samples row on the same edge it holds col sees the correct response.

## Test plan

- Reset with cmd_valid = 1 held for 2 cycles -> row = 1111, cmd_ready = 0, busy = 0, done = 0; after reset is released, the command is accepted on the first cycle.
- Defaults, cmd_key = 0, col held at 0111, accepted at N -> row = 0111 at N+1 and N+3, 1111 at N+2 and N+4, 0111 for N+5..N+20, 1111 for N+21..N+28; done = 1 only at N+29.
- cmd_key = 6 (r1,c2), col cycling 0111, 1011, 1101, 1110 during HOLD -> row = 1011 exactly in the cycles where col = 1101, and 1111 otherwise.
- During HOLD with key 0, col = 1111 and then col = 0011 -> row = 1111 in both cycles; with col = 0111 restored, row = 0111.
- Second cmd_valid asserted during BOUNCE with a different key -> cmd_ready = 0 and the key is ignored; the same request held is accepted at the done cycle, and its press reports the new key.
- rst asserted at the 5th HOLD cycle -> next cycle row = 1111, busy = 0; no done pulse follows. Repeat with BOUNCE_CYCLES = 0: row = 0111 from N+1 with no bounce toggling.
